// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 4-way decoder select through masked channels with blanking and dwell
module scan_sequencer #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         chan_mask,
  output logic [1:0]         sel,
  output logic               enable,
  output logic               busy,
  output logic               frame_done
);
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam bit NO_BLANK = BLANK_CYCLES == 0;
  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;
  state_t             state_q;
  logic [1:0]         sel_q;
  logic               enable_q, busy_q, frame_done_q, stop_q;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic [BW-1:0]      bcnt_q;
  logic [1:0]         next_sel_d;
  logic               has_next_d;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) lowest = 2'(i);
  endfunction
  // Next set mask bit strictly above the current channel; absence marks the frame end
  always_comb begin
    has_next_d = 1'b0;
    next_sel_d = lowest(mask_q);
    for (int i = 3; i >= 0; i--)
      if (mask_q[i] && 2'(i) > sel_q) begin
        has_next_d = 1'b1;
        next_sel_d = 2'(i);
      end
  end
  // Scan FSM; every output is a register so the decoder never sees input-driven glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      stop_q       <= 1'b0;
      mask_q       <= 4'd0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q != IDLE && stop) stop_q <= 1'b1;
      case (state_q)
        IDLE:
          if (start && chan_mask != 4'd0) begin
            mask_q   <= chan_mask;
            dwell_q  <= dwell == '0 ? DWELL_W'(1) : dwell;
            sel_q    <= lowest(chan_mask);
            state_q  <= NO_BLANK ? ACTIVE : BLANK;
            enable_q <= NO_BLANK;
            busy_q   <= 1'b1;
            bcnt_q   <= '0;
            cnt_q    <= '0;
          end
        BLANK:
          if (bcnt_q == BW'(BLANK_CYCLES - 1)) begin
            state_q  <= ACTIVE;
            enable_q <= 1'b1;
            cnt_q    <= '0;
          end else bcnt_q <= bcnt_q + BW'(1);
        ACTIVE:
          if (cnt_q == dwell_q - DWELL_W'(1)) begin
            if (has_next_d) begin
              sel_q    <= next_sel_d;
              state_q  <= NO_BLANK ? ACTIVE : BLANK;
              enable_q <= NO_BLANK;
              bcnt_q   <= '0;
              cnt_q    <= '0;
            end else begin
              frame_done_q <= 1'b1;
              if (stop_q || stop || chan_mask == 4'd0) begin
                state_q  <= IDLE;
                enable_q <= 1'b0;
                busy_q   <= 1'b0;
                stop_q   <= 1'b0;
              end else begin
                mask_q   <= chan_mask;
                dwell_q  <= dwell == '0 ? DWELL_W'(1) : dwell;
                sel_q    <= lowest(chan_mask);
                state_q  <= NO_BLANK ? ACTIVE : BLANK;
                enable_q <= NO_BLANK;
                bcnt_q   <= '0;
                cnt_q    <= '0;
              end
            end
          end else cnt_q <= cnt_q + DWELL_W'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sel        = sel_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
endmodule
